// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: sync, visible-area flags, coordinates and early strobes.
// Optional frame counter is built only when FRAME_COUNTER_EN is defined.
module video_timing_gen #(
    parameter int H_VISIBLE         = 800,
    parameter int H_FRONT_PORCH     = 40,
    parameter int H_SYNC            = 128,
    parameter int H_BACK_PORCH      = 88,
    parameter int V_VISIBLE         = 600,
    parameter int V_FRONT_PORCH     = 1,
    parameter int V_SYNC            = 4,
    parameter int V_BACK_PORCH      = 23,
    parameter int HSYNC_POSITIVE    = 1,
    parameter int VSYNC_POSITIVE    = 1,
    parameter int H_WIDTH           = 11,
    parameter int V_WIDTH           = 10,
    parameter int PIPELINE_DELAY    = 0,
    parameter int H_SCALE_SHIFT     = 0,
    parameter int V_SCALE_SHIFT     = 0,
    parameter int FRAME_COUNT_WIDTH = 8
) (
    input  logic                         clk40,
    input  logic                         reset,
    input  logic                         enable,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         videoActive,
    output logic                         lineStarting,
    output logic                         lineEnding,
    output logic                         hsyncStarting,
    output logic                         frameStarting,
    output logic                         vblankStarting,
    output logic [H_WIDTH-1:0]           hPos,
    output logic [V_WIDTH-1:0]           vPos,
    output logic                         nextFrameActive,
    output logic [V_WIDTH-1:0]           nextVPos,
    output logic [FRAME_COUNT_WIDTH-1:0] frameCount
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    localparam int HS_START = H_VISIBLE + H_FRONT_PORCH;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT_PORCH;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int ADVANCE  = PIPELINE_DELAY + 1;

    localparam logic [H_WIDTH-1:0] H_LAST     = H_WIDTH'(H_TOTAL - 1);
    localparam logic [H_WIDTH-1:0] H_VIS      = H_WIDTH'(H_VISIBLE);
    localparam logic [H_WIDTH-1:0] H_VIS_LAST = H_WIDTH'(H_VISIBLE - 1);
    localparam logic [H_WIDTH-1:0] HS_SET     = H_WIDTH'(HS_START - 1);
    localparam logic [H_WIDTH-1:0] HS_CLR     = H_WIDTH'(HS_END - 1);

    // Strobe positions wrap modulo the line length so small porches still work.
    localparam logic [H_WIDTH-1:0] LS_AT  = H_WIDTH'((H_TOTAL - ADVANCE) % H_TOTAL);
    localparam logic [H_WIDTH-1:0] LE_AT  = H_WIDTH'((H_VISIBLE - ADVANCE + H_TOTAL) % H_TOTAL);
    localparam logic [H_WIDTH-1:0] HSS_AT = H_WIDTH'((HS_START - ADVANCE + H_TOTAL) % H_TOTAL);

    localparam logic [V_WIDTH-1:0] V_LAST     = V_WIDTH'(V_TOTAL - 1);
    localparam logic [V_WIDTH-1:0] V_VIS      = V_WIDTH'(V_VISIBLE);
    localparam logic [V_WIDTH-1:0] V_VIS_LAST = V_WIDTH'(V_VISIBLE - 1);
    localparam logic [V_WIDTH:0]   VS_LO      = (V_WIDTH+1)'(VS_START);
    localparam logic [V_WIDTH:0]   VS_HI      = (V_WIDTH+1)'(VS_END);

    logic [H_WIDTH-1:0] hcount;
    logic [V_WIDTH-1:0] vcount;
    logic [V_WIDTH-1:0] next_vcount;
    logic               hsync_active;
    logic               vsync_active;
    logic               running;
    logic               next_in_vsync;
    logic               h_visible;

    assign running       = enable && !reset;
    assign next_in_vsync = ({1'b0, next_vcount} >= VS_LO) && ({1'b0, next_vcount} < VS_HI);

    // next_vcount is settled at the end of the visible line so nextVPos is stable in blanking.
    always_ff @(posedge clk40) begin
        if (reset || !enable) begin
            hcount       <= '0;
            vcount       <= '0;
            next_vcount  <= '0;
            hsync_active <= 1'b0;
            vsync_active <= 1'b0;
        end else begin
            if (hcount == H_LAST) begin
                hcount       <= '0;
                vcount       <= next_vcount;
                vsync_active <= next_in_vsync;
            end else begin
                hcount <= hcount + 1'b1;
            end

            if (hcount == H_VIS_LAST) begin
                next_vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end

            if (hcount == HS_SET) begin
                hsync_active <= 1'b1;
            end else if (hcount == HS_CLR) begin
                hsync_active <= 1'b0;
            end
        end
    end

    assign hsync = (HSYNC_POSITIVE != 0) ? hsync_active : ~hsync_active;
    assign vsync = (VSYNC_POSITIVE != 0) ? vsync_active : ~vsync_active;

    assign h_visible   = (hcount < H_VIS);
    assign videoActive = h_visible && (vcount < V_VIS);
    assign hPos        = h_visible ? (hcount >> H_SCALE_SHIFT) : '0;
    assign vPos        = (vcount < V_VIS) ? (vcount >> V_SCALE_SHIFT) : '0;

    assign nextFrameActive = (next_vcount < V_VIS);
    assign nextVPos        = nextFrameActive ? (next_vcount >> V_SCALE_SHIFT) : '0;

    assign lineStarting   = running && (hcount == LS_AT);
    assign lineEnding     = running && (hcount == LE_AT);
    assign hsyncStarting  = running && (hcount == HSS_AT);
    assign frameStarting  = lineStarting && (vcount == V_LAST);
    assign vblankStarting = running && (hcount == H_LAST) && (vcount == V_VIS_LAST);

`ifdef FRAME_COUNTER_EN
    logic [FRAME_COUNT_WIDTH-1:0] frame_count;

    // Counts completed frames: bumps on the same edge as vcount wrapping to 0.
    always_ff @(posedge clk40) begin
        if (reset || !enable) begin
            frame_count <= '0;
        end else if ((hcount == H_LAST) && (vcount == V_LAST)) begin
            frame_count <= frame_count + 1'b1;
        end
    end

    assign frameCount = frame_count;
`else
    assign frameCount = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two small modes checked every cycle against a raster model,
// plus a directed vector table and hand-written corner sequences.
module tb_video_timing_gen;

    typedef struct {
        int hv, hfp, hs, hbp;
        int vv, vfp, vs, vbp;
        int hpol, vpol, pd, hsh, vsh, fcw;
    } mode_t;

    typedef struct {
        logic        hsync, vsync, video_active;
        logic        line_starting, line_ending, hsync_starting;
        logic        frame_starting, vblank_starting, next_frame_active;
        logic [15:0] hpos, vpos, next_vpos, frame_count;
    } rec_t;

    typedef struct {
        logic rst;
        logic en;
        int   cycles;
        int   exp_ls;
        int   exp_hs;
        int   exp_vb;
        int   exp_fs;
    } vec_t;

    localparam mode_t MODE_A = '{16, 4, 6, 6, 8, 1, 2, 3, 1, 1, 2, 1, 1, 2};
    localparam mode_t MODE_B = '{20, 3, 5, 2, 6, 2, 2, 2, 0, 0, 0, 0, 0, 8};

    logic clk;
    logic reset;
    logic enable;

    logic       a_hsync, a_vsync, a_video_active, a_line_starting, a_line_ending;
    logic       a_hsync_starting, a_frame_starting, a_vblank_starting, a_next_frame_active;
    logic [5:0] a_hpos;
    logic [3:0] a_vpos, a_next_vpos;
    logic [1:0] a_frame_count;

    logic       b_hsync, b_vsync, b_video_active, b_line_starting, b_line_ending;
    logic       b_hsync_starting, b_frame_starting, b_vblank_starting, b_next_frame_active;
    logic [4:0] b_hpos;
    logic [3:0] b_vpos, b_next_vpos;
    logic [7:0] b_frame_count;

    int checks = 0;
    int errors = 0;
    int t_run  = 0;
    int seg_ls, seg_hs, seg_vb, seg_fs;

    video_timing_gen #(
        .H_VISIBLE(16), .H_FRONT_PORCH(4), .H_SYNC(6), .H_BACK_PORCH(6),
        .V_VISIBLE(8), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(3),
        .HSYNC_POSITIVE(1), .VSYNC_POSITIVE(1), .H_WIDTH(6), .V_WIDTH(4),
        .PIPELINE_DELAY(2), .H_SCALE_SHIFT(1), .V_SCALE_SHIFT(1), .FRAME_COUNT_WIDTH(2)
    ) u_a (
        .clk40(clk), .reset(reset), .enable(enable),
        .hsync(a_hsync), .vsync(a_vsync), .videoActive(a_video_active),
        .lineStarting(a_line_starting), .lineEnding(a_line_ending),
        .hsyncStarting(a_hsync_starting), .frameStarting(a_frame_starting),
        .vblankStarting(a_vblank_starting), .hPos(a_hpos), .vPos(a_vpos),
        .nextFrameActive(a_next_frame_active), .nextVPos(a_next_vpos),
        .frameCount(a_frame_count)
    );

    video_timing_gen #(
        .H_VISIBLE(20), .H_FRONT_PORCH(3), .H_SYNC(5), .H_BACK_PORCH(2),
        .V_VISIBLE(6), .V_FRONT_PORCH(2), .V_SYNC(2), .V_BACK_PORCH(2),
        .HSYNC_POSITIVE(0), .VSYNC_POSITIVE(0), .H_WIDTH(5), .V_WIDTH(4),
        .PIPELINE_DELAY(0), .H_SCALE_SHIFT(0), .V_SCALE_SHIFT(0), .FRAME_COUNT_WIDTH(8)
    ) u_b (
        .clk40(clk), .reset(reset), .enable(enable),
        .hsync(b_hsync), .vsync(b_vsync), .videoActive(b_video_active),
        .lineStarting(b_line_starting), .lineEnding(b_line_ending),
        .hsyncStarting(b_hsync_starting), .frameStarting(b_frame_starting),
        .vblankStarting(b_vblank_starting), .hPos(b_hpos), .vPos(b_vpos),
        .nextFrameActive(b_next_frame_active), .nextVPos(b_next_vpos),
        .frameCount(b_frame_count)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // Raster model: position follows directly from the number of enabled cycles since restart.
    function automatic rec_t model(mode_t m, int t, bit run);
        rec_t r;
        int ht, vt, h, v, fr, nv;
        int ls_at, le_at, hss_at;
        bit hs_act, vs_act;
        ht = m.hv + m.hfp + m.hs + m.hbp;
        vt = m.vv + m.vfp + m.vs + m.vbp;
        h  = t % ht;
        v  = (t / ht) % vt;
        fr = t / (ht * vt);
        ls_at  = (ht - m.pd - 1) % ht;
        le_at  = (m.hv - m.pd - 1 + ht) % ht;
        hss_at = (m.hv + m.hfp - m.pd - 1 + ht) % ht;
        hs_act = (h >= m.hv + m.hfp) && (h < m.hv + m.hfp + m.hs);
        vs_act = (v >= m.vv + m.vfp) && (v < m.vv + m.vfp + m.vs);
        r.hsync           = (m.hpol != 0) ? hs_act : !hs_act;
        r.vsync           = (m.vpol != 0) ? vs_act : !vs_act;
        r.video_active    = (h < m.hv) && (v < m.vv);
        r.line_starting   = run && (h == ls_at);
        r.line_ending     = run && (h == le_at);
        r.hsync_starting  = run && (h == hss_at);
        r.frame_starting  = run && (h == ls_at) && (v == vt - 1);
        r.vblank_starting = run && (h == ht - 1) && (v == m.vv - 1);
        r.hpos            = (h < m.hv) ? 16'(h >> m.hsh) : 16'd0;
        r.vpos            = (v < m.vv) ? 16'(v >> m.vsh) : 16'd0;
        nv                = (h >= m.hv) ? (v + 1) % vt : v;
        r.next_frame_active = (nv < m.vv);
        r.next_vpos       = (nv < m.vv) ? 16'(nv >> m.vsh) : 16'd0;
`ifdef FRAME_COUNTER_EN
        r.frame_count     = 16'(fr % (1 << m.fcw));
`else
        r.frame_count     = 16'(fr * 0);
`endif
        return r;
    endfunction

    function automatic rec_t get_a();
        rec_t r;
        r.hsync = a_hsync; r.vsync = a_vsync; r.video_active = a_video_active;
        r.line_starting = a_line_starting; r.line_ending = a_line_ending;
        r.hsync_starting = a_hsync_starting; r.frame_starting = a_frame_starting;
        r.vblank_starting = a_vblank_starting; r.next_frame_active = a_next_frame_active;
        r.hpos = 16'(a_hpos); r.vpos = 16'(a_vpos); r.next_vpos = 16'(a_next_vpos);
        r.frame_count = 16'(a_frame_count);
        return r;
    endfunction

    function automatic rec_t get_b();
        rec_t r;
        r.hsync = b_hsync; r.vsync = b_vsync; r.video_active = b_video_active;
        r.line_starting = b_line_starting; r.line_ending = b_line_ending;
        r.hsync_starting = b_hsync_starting; r.frame_starting = b_frame_starting;
        r.vblank_starting = b_vblank_starting; r.next_frame_active = b_next_frame_active;
        r.hpos = 16'(b_hpos); r.vpos = 16'(b_vpos); r.next_vpos = 16'(b_next_vpos);
        r.frame_count = 16'(b_frame_count);
        return r;
    endfunction

    // scoreboard
    task automatic chk_bit(string tag, string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s t=%0d: got %b expected %b", tag, name, t_run, act, exp);
        end
    endtask

    task automatic chk_val(string tag, string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s t=%0d: got %0d expected %0d", tag, name, t_run, act, exp);
        end
    endtask

    task automatic compare_rec(string tag, rec_t act, rec_t exp);
        chk_bit(tag, "hsync", act.hsync, exp.hsync);
        chk_bit(tag, "vsync", act.vsync, exp.vsync);
        chk_bit(tag, "videoActive", act.video_active, exp.video_active);
        chk_bit(tag, "lineStarting", act.line_starting, exp.line_starting);
        chk_bit(tag, "lineEnding", act.line_ending, exp.line_ending);
        chk_bit(tag, "hsyncStarting", act.hsync_starting, exp.hsync_starting);
        chk_bit(tag, "frameStarting", act.frame_starting, exp.frame_starting);
        chk_bit(tag, "vblankStarting", act.vblank_starting, exp.vblank_starting);
        chk_bit(tag, "nextFrameActive", act.next_frame_active, exp.next_frame_active);
        chk_val(tag, "hPos", act.hpos, exp.hpos);
        chk_val(tag, "vPos", act.vpos, exp.vpos);
        chk_val(tag, "nextVPos", act.next_vpos, exp.next_vpos);
        chk_val(tag, "frameCount", act.frame_count, exp.frame_count);
    endtask

    // driver: one clock, model update, compare half a cycle later
    task automatic step();
        bit run;
        @(posedge clk);
        if (reset || !enable) t_run = 0;
        else t_run++;
        @(negedge clk);
        run = enable && !reset;
        compare_rec("a", get_a(), model(MODE_A, t_run, run));
        compare_rec("b", get_b(), model(MODE_B, t_run, run));
        seg_ls += int'(a_line_starting);
        seg_hs += int'(a_hsync);
        seg_vb += int'(a_vblank_starting);
        seg_fs += int'(a_frame_starting);
    endtask

    task automatic restart();
        reset  = 1'b1;
        enable = 1'b0;
        step();
        reset  = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        vec_t vecs[5];
        int   fc_exp[5];
        int   n;
        int   r;

        vecs[0] = '{1'b1, 1'b0,   4,  0,  0, 0, 0};
        vecs[1] = '{1'b0, 1'b1,  32,  1,  6, 0, 0};
        vecs[2] = '{1'b0, 1'b1, 416, 13, 78, 1, 1};
        vecs[3] = '{1'b0, 1'b0,  10,  0,  0, 0, 0};
        vecs[4] = '{1'b1, 1'b1,   3,  0,  0, 0, 0};
`ifdef FRAME_COUNTER_EN
        fc_exp = '{1, 2, 3, 0, 1};
`else
        fc_exp = '{0, 0, 0, 0, 0};
`endif

        reset  = 1'b1;
        enable = 1'b0;

        // vector table: per-segment strobe and hsync totals on the PIPELINE_DELAY=2 mode
        for (int i = 0; i < 5; i++) begin
            reset  = vecs[i].rst;
            enable = vecs[i].en;
            seg_ls = 0; seg_hs = 0; seg_vb = 0; seg_fs = 0;
            repeat (vecs[i].cycles) step();
            chk_val("vec", $sformatf("lineStarting_count[%0d]", i), 16'(seg_ls), 16'(vecs[i].exp_ls));
            chk_val("vec", $sformatf("hsync_high_count[%0d]", i), 16'(seg_hs), 16'(vecs[i].exp_hs));
            chk_val("vec", $sformatf("vblank_count[%0d]", i), 16'(seg_vb), 16'(vecs[i].exp_vb));
            chk_val("vec", $sformatf("frameStarting_count[%0d]", i), 16'(seg_fs), 16'(vecs[i].exp_fs));
        end

        // scaled coordinates and next-line lookahead around the bottom of the frame
        restart();
        repeat (15) step();
        chk_val("a", "hPos_at_h15", 16'(a_hpos), 16'd7);
        repeat (225) step();
        chk_val("a", "hPos_at_h16", 16'(a_hpos), 16'd0);
        chk_val("a", "vPos_line7", 16'(a_vpos), 16'd3);
        chk_bit("a", "nextFrameActive_line7", a_next_frame_active, 1'b0);
        chk_val("a", "nextVPos_line7", 16'(a_next_vpos), 16'd0);
        repeat (192) step();
        chk_bit("a", "nextFrameActive_line13", a_next_frame_active, 1'b1);
        chk_val("a", "nextVPos_line13", 16'(a_next_vpos), 16'd0);

        // frame counter across five wraps
        restart();
        for (int k = 0; k < 5; k++) begin
            repeat (448) step();
            chk_val("a", $sformatf("frameCount_wrap%0d", k), 16'(a_frame_count), 16'(fc_exp[k]));
        end

        // hsync latency from enable on the active-low mode
        restart();
        n = 0;
        while (b_hsync !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        chk_val("b", "hsync_latency", 16'(n), 16'd23);

        // mid-frame disable then resume at pixel 0 of line 0
        repeat (137) step();
        enable = 1'b0;
        repeat (10) step();
        chk_bit("b", "hsync_disabled", b_hsync, 1'b1);
        chk_bit("b", "vsync_disabled", b_vsync, 1'b1);
        chk_bit("b", "lineStarting_disabled", b_line_starting, 1'b0);
        enable = 1'b1;
        step();
        chk_val("b", "hPos_resume", 16'(b_hpos), 16'd1);
        chk_val("b", "vPos_resume", 16'(b_vpos), 16'd0);
        chk_val("b", "frameCount_resume", 16'(b_frame_count), 16'd0);

        // randomized run/stop/reset traffic checked by the model every cycle
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                reset  = 1'b0;
                enable = 1'b1;
                repeat ($urandom_range(20, 600)) step();
            end else if (r < 9) begin
                reset  = 1'b0;
                enable = 1'b0;
                repeat ($urandom_range(1, 15)) step();
            end else begin
                reset  = 1'b1;
                enable = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the display pipeline: produces registered hsync/vsync, visible-area flags, pixel/line coordinates and early-warning strobes for any VESA-style mode, not just the fixed 800x600@60 one. It adds a run/stop enable, coordinate down-scaling for pixel/line doubling, a vertical-blank strobe and an optional frame counter. It sits at the head of the video path and drives the fetch/pipeline stages and the DAC sync pins.

## Interface
- H_VISIBLE, 800, visible pixels per line
- H_FRONT_PORCH, 40, pixels
- H_SYNC, 128, pixels
- H_BACK_PORCH, 88, pixels
- V_VISIBLE, 600, visible lines
- V_FRONT_PORCH, 1, lines
- V_SYNC, 4, lines
- V_BACK_PORCH, 23, lines
- HSYNC_POSITIVE, 1, 1 = hsync active high
- VSYNC_POSITIVE, 1, 1 = vsync active high
- H_WIDTH, 11, horizontal counter width; must hold H_TOTAL-1
- V_WIDTH, 10, vertical counter width; must hold V_TOTAL-1
- PIPELINE_DELAY, 0, strobe advance in pixels; 0 ≤ value < H_FRONT_PORCH
- H_SCALE_SHIFT, 0, hPos = hcount >> shift
- V_SCALE_SHIFT, 0, vPos/nextVPos = line >> shift
- FRAME_COUNT_WIDTH, 8, frameCount width

Ports:
- clk40  input  1  pixel clock
- reset  input  1  synchronous, active-high
- enable  input  1  1 = run; 0 = held in reset state
- hsync  output  1  registered
- vsync  output  1  registered
- videoActive  output  1  hcount < H_VISIBLE and vcount < V_VISIBLE
- lineStarting  output  1  one-pixel strobe, PIPELINE_DELAY+1 pixels before pixel 0
- lineEnding  output  1  one-pixel strobe, PIPELINE_DELAY+1 pixels before first front-porch pixel
- hsyncStarting  output  1  one-pixel strobe, PIPELINE_DELAY+1 pixels before hsync asserts
- frameStarting  output  1  lineStarting on line V_TOTAL-1
- vblankStarting  output  1  hcount==H_TOTAL-1 and vcount==V_VISIBLE-1
- hPos  output  H_WIDTH  scaled pixel index; 0 outside visible line
- vPos  output  V_WIDTH  scaled line index; 0 outside visible frame
- nextFrameActive  output  1  upcoming line is visible
- nextVPos  output  V_WIDTH  scaled upcoming line; 0 if not visible
- frameCount  output  FRAME_COUNT_WIDTH  completed frames (with FRAME_COUNTER_EN only)

## Operation
- H_TOTAL = sum of H_*; V_TOTAL = sum of V_*.
- hcount 0..H_TOTAL-1, +1 per clock, wraps to 0. On wrap, vcount <= nextVcount.
- nextVcount loaded at hcount==H_VISIBLE-1 with (vcount==V_TOTAL-1 ? 0 : vcount+1); hence nextVPos is valid throughout horizontal blanking.
- hsync active exactly for hcount in [H_VISIBLE+H_FRONT_PORCH, +H_SYNC); set/cleared by registers decoded one pixel earlier.
- vsync active for vcount in [V_VISIBLE+V_FRONT_PORCH, +V_SYNC); transitions on the same edge as the vcount update.
- Strobes are combinational decodes of hcount/vcount, gated by enable and forced 0 while reset is high; strobe compare values are modulo H_TOTAL.
- reset or enable==0 (reset has priority): hcount=0, vcount=0, nextVcount=0, hsync/vsync inactive, frameCount=0. All strobes 0. videoActive is then combinationally 1 and hPos/vPos 0. Resuming: the first enabled cycle is pixel 0 of line 0.
- Mid-frame reset/disable: takes effect on the next edge, and there is no partial-frame completion.

## Timing
- Latency from enable rising to hsync assert: H_VISIBLE+H_FRONT_PORCH cycles.
- Only one H-wrap and one vcount update happen per line; frame wrap V_TOTAL-1 -> 0 coincides with the frameCount increment.
- vblankStarting and the vcount transition into V_VISIBLE occur on the same edge; frameStarting precedes pixel (0,0) by PIPELINE_DELAY+1 cycles.

## Configuration
- FRAME_COUNTER_EN defined: the frameCount register is present and increments (wrapping) on each vcount V_TOTAL-1 -> 0 transition.
- FRAME_COUNTER_EN undefined: frameCount is tied to 0 and no counter logic is generated; all other behaviour is identical.

## Test plan
- Defaults, reset then enable=1, run for 2 frames -> 1056 clocks per hsync period; hsync high for 128 clocks starting at hcount 840; vsync high for 4 lines starting at line 601; frame = 663168 clocks.
- PIPELINE_DELAY=2 -> lineStarting at hcount 1053, lineEnding at 797, hsyncStarting at 837; each strobe one cycle wide.
- H_SCALE_SHIFT=1, V_SCALE_SHIFT=1 -> hPos 0..399 (each value held 2 clocks), vPos 0..299; hPos=0 at hcount 800.
- At hcount 800 on line 599 -> nextFrameActive=0 and nextVPos=0; at hcount 800 on line 627 -> nextVPos=0 and nextFrameActive=1.
- Drop enable at line 300 for 10 cycles, then raise it -> hsync/vsync inactive and strobes 0 while enable=0; after re-enable, pixel 0 line 0 and frameCount=0.
- With FRAME_COUNTER_EN, FRAME_COUNT_WIDTH=2, run 5 frames -> frameCount goes 1,2,3,0,1 on the frame wraps; without the macro, frameCount stays 0.
